// File: rtl/vend_pkg.sv
// Shared constants for the vending engine: controller state codes, coin codes
// and the default price / coin-value tables.
`timescale 1ns/1ps
package vend_pkg;

  // Controller states
  typedef logic [1:0] vend_state_t;
  localparam vend_state_t ST_IDLE    = 2'd0;
  localparam vend_state_t ST_COLLECT = 2'd1;
  localparam vend_state_t ST_VEND    = 2'd2;
  localparam vend_state_t ST_CHANGE  = 2'd3;

  // Coin denomination codes as seen on coin_sel / change_sel
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_20   = 2'd3;

  // Default tables, item/code i lives in slice [i*8 +: 8]
  localparam logic [31:0] DEF_ITEM_PRICES = {8'd100, 8'd50, 8'd20, 8'd10};
  localparam logic [31:0] DEF_COIN_VALUES = {8'd20, 8'd10, 8'd5, 8'd0};

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest nonzero coin value that still
// fits in the remaining balance. found=0 means nothing fits (residue).
`timescale 1ns/1ps
module vend_change_sel #(
  parameter int BAL_W = 8
) (
  input  logic [BAL_W-1:0]   balance,
  input  logic [4*BAL_W-1:0] coin_values,
  output logic [1:0]         change_sel,
  output logic [BAL_W-1:0]   coin_value,
  output logic               found
);

  // Scan all four codes; the table need not be sorted, so keep the maximum.
  always_comb begin
    change_sel = 2'd0;
    coin_value = '0;
    found      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((coin_values[k*BAL_W +: BAL_W] != '0) &&
          (coin_values[k*BAL_W +: BAL_W] <= balance) &&
          (coin_values[k*BAL_W +: BAL_W] > coin_value)) begin
        coin_value = coin_values[k*BAL_W +: BAL_W];
        change_sel = k[1:0];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_core.sv
// Vending engine: coin collection, item vend with stock/funds checks,
// cancel/timeout refund and coin-by-coin greedy change return.
`timescale 1ns/1ps
module vend_core
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int BAL_W       = 8,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 8,
  parameter logic [NUM_ITEMS*BAL_W-1:0] ITEM_PRICES = DEF_ITEM_PRICES,
  parameter logic [4*BAL_W-1:0]         COIN_VALUES = DEF_COIN_VALUES,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_sel,
  input  logic                 item_valid,
  input  logic [IW-1:0]        item_sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 vend_valid,
  output logic [IW-1:0]        vend_item,
  output logic                 change_valid,
  output logic [1:0]           change_sel,
  output logic                 coin_reject,
  output logic                 err_soldout,
  output logic                 err_funds,
  output logic [BAL_W-1:0]     balance,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  vend_state_t                  state_reg;
  logic [TW-1:0]                tmo_cnt_reg;
  logic [IW-1:0]                item_reg;
  logic [NUM_ITEMS*STOCK_W-1:0] stock_flat;

  logic [BAL_W-1:0]   coin_val;
  logic [BAL_W:0]     coin_sum;
  logic               coin_ok;
  logic               item_in_range;
  logic [STOCK_W-1:0] sel_stock;
  logic [BAL_W-1:0]   sel_price;
  logic               stock_ok;
  logic               funds_ok;
  logic               item_go;
  logic               tmo_hit;
  logic [1:0]         chg_code;
  logic [BAL_W-1:0]   chg_value;
  logic               chg_found;

  // Coin acceptance: known denomination and no balance overflow
  assign coin_val = COIN_VALUES[coin_sel*BAL_W +: BAL_W];
  assign coin_sum = {1'b0, balance} + {1'b0, coin_val};
  assign coin_ok  = coin_valid && (coin_val != '0) && !coin_sum[BAL_W];

  // Item request qualification; out-of-range indices are treated as sold out
  assign item_in_range = (32'(item_sel) < NUM_ITEMS);
  assign sel_stock     = item_in_range ? stock_flat[item_sel*STOCK_W +: STOCK_W] : '0;
  assign sel_price     = item_in_range ? ITEM_PRICES[item_sel*BAL_W +: BAL_W] : '0;
  assign stock_ok      = item_in_range && (sel_stock != '0);
  assign funds_ok      = (balance >= sel_price);
  assign item_go       = item_valid && stock_ok && funds_ok;

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_reg == TMO_LAST);
  assign busy    = (state_reg == ST_VEND) || (state_reg == ST_CHANGE);

  vend_change_sel #(.BAL_W(BAL_W)) u_change_sel (
    .balance     (balance),
    .coin_values (COIN_VALUES),
    .change_sel  (chg_code),
    .coin_value  (chg_value),
    .found       (chg_found)
  );

  // Per-item stock counters: reload on restock in IDLE, count down on dispense
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
    logic [STOCK_W-1:0] stock_reg;

    // Decrement is guarded so a counter never wraps below zero
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stock_reg <= STOCK_W'(INIT_STOCK);
      end else if ((state_reg == ST_IDLE) && restock) begin
        stock_reg <= STOCK_W'(INIT_STOCK);
      end else if ((state_reg == ST_VEND) && (item_reg == IW'(gi)) && (stock_reg != '0)) begin
        stock_reg <= stock_reg - 1'b1;
      end
    end

    assign stock_flat[gi*STOCK_W +: STOCK_W] = stock_reg;
    assign sold_out[gi] = (stock_reg == '0);
  end

  // Controller FSM with registered balance and one-cycle output pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      balance      <= '0;
      tmo_cnt_reg  <= '0;
      item_reg     <= '0;
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_sel   <= COIN_NONE;
      coin_reject  <= 1'b0;
      err_soldout  <= 1'b0;
      err_funds    <= 1'b0;
    end else begin
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      err_soldout  <= 1'b0;
      err_funds    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (coin_ok) begin
            balance     <= coin_sum[BAL_W-1:0];
            tmo_cnt_reg <= '0;
            state_reg   <= ST_COLLECT;
          end else begin
            coin_reject <= coin_valid;
          end
        end
        ST_COLLECT: begin
          // Any cancel or item request takes the cycle; a coin alongside it bounces
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          coin_reject <= coin_valid && (cancel || item_valid || !coin_ok);
          err_soldout <= !cancel && item_valid && !stock_ok;
          err_funds   <= !cancel && item_valid && stock_ok && !funds_ok;
          if (cancel) begin
            state_reg <= ST_CHANGE;
          end else if (item_go) begin
            balance   <= balance - sel_price;
            item_reg  <= item_sel;
            state_reg <= ST_VEND;
          end else if (!item_valid && coin_ok) begin
            balance     <= coin_sum[BAL_W-1:0];
            tmo_cnt_reg <= '0;
          end else if (tmo_hit) begin
            state_reg <= ST_CHANGE;
          end
        end
        ST_VEND: begin
          vend_valid  <= 1'b1;
          vend_item   <= item_reg;
          coin_reject <= coin_valid;
          state_reg   <= (balance != '0) ? ST_CHANGE : ST_IDLE;
        end
        default: begin
          // ST_CHANGE: one coin per cycle; an unpayable residue is forfeited
          coin_reject <= coin_valid;
          if (chg_found) begin
            change_valid <= 1'b1;
            change_sel   <= chg_code;
            balance      <= balance - chg_value;
            if (balance == chg_value) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            balance   <= '0;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
